// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter that is the sole writer of a shared holding register,
// with per-requester lockable multi-beat bursts.
module rr_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          lock_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [DATA_W-1:0]           q_o,
  output logic                        q_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        locked_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [DATA_W-1:0]   r_q;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_ptr;

  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [DATA_W-1:0]   w_q_nxt;
  logic [IDX_W-1:0]    w_owner_nxt;
  logic [IDX_W-1:0]    w_ptr_nxt;

  logic [NUM_REQ-1:0]  w_elig;
  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_win_inc;
  logic                w_do_arb;

  // Masking out the current grantee keeps a dropping requester from being granted twice.
  assign w_elig = req_i & ~r_gnt;

  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(v_idx);
      end
    end
  end

  assign w_win_inc = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_q_nxt     = r_q;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_do_arb    = 1'b0;

    case (r_state)
      ST_LOCKED: begin
        if (req_i[r_owner]) begin
          w_gnt_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
          w_q_nxt   = data_i[int'(r_owner)*DATA_W +: DATA_W];
          if (!lock_i[r_owner]) begin
            w_state_nxt = ST_ARB;
          end
        end else begin
          // Abandoned burst: re-arbitrate on this same edge.
          w_state_nxt = ST_ARB;
          w_do_arb    = 1'b1;
        end
      end
      default: begin
        w_do_arb = 1'b1;
      end
    endcase

    if (w_do_arb && w_found) begin
      w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
      w_q_nxt     = data_i[int'(w_win)*DATA_W +: DATA_W];
      w_owner_nxt = w_win;
      w_ptr_nxt   = w_win_inc;
      w_state_nxt = lock_i[w_win] ? ST_LOCKED : ST_ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_gnt   <= '0;
      r_q     <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_q     <= w_q_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign q_o       = r_q;
  assign q_valid_o = |r_gnt;
  assign owner_o   = r_owner;
  assign locked_o  = (r_state == ST_LOCKED);

endmodule
